// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB565 camera capture into an RGB444 frame-buffer write port
//
// Samples the camera bus (pclk/href/vsync/data) as plain data in the clk100mhz
// domain, assembles two RGB565 bytes per pixel and emits one RGB444 write per
// stored pixel at line-major addresses starting at 0.
//
// Ports:
//   clk100mhz   in   system clock, the only clock
//   reset       in   synchronous, active-high
//   cam_pclk    in   camera pixel clock, oversampled as data
//   cam_vsync   in   frame sync, high = vertical blanking
//   cam_href    in   line valid
//   cam_data    in   [7:0] camera byte, RGB565 high byte first
//   wr_en       out  one-cycle write strobe
//   wr_addr     out  [ADDR_W-1:0] pixel address
//   wr_data     out  [11:0] RGB444 pixel
//   frame_done  out  one-cycle pulse after a captured frame ends
//   overflow    out  sticky: more pixels than H_PIXELS*V_LINES this frame
//
// Optional build macro CAPTURE_DECIMATE_EN: keep only even pixels of even
// lines (640x480 input stored as 320x240).

module ov7670_capture #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              clk100mhz,
    input  logic              reset,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              overflow
);

    localparam int unsigned FRAME_PIXELS = H_PIXELS * V_LINES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        SYNC_WAIT  = 2'd0,
        FRAME_WAIT = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Two-flop synchronizers, equal depth on every camera input so that
    // href/data line up with the pclk edge that qualifies them.
    logic [1:0] pclk_s_q, href_s_q, vsync_s_q;
    logic [7:0] data_s1_q, data_s2_q;
    logic       pclk_prev_q, href_prev_q, vsync_prev_q;

    logic              phase_q;
    logic [7:0]        byte0_q;
    logic [ADDR_W-1:0] addr_q;
    logic              full_q;
    logic              wr_en_q, frame_done_q, overflow_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [11:0]       wr_data_q;

    logic sample, href_fall, vsync_rise, vsync_fall;
    logic frame_start, frame_end, keep;

    assign sample     = pclk_s_q[1] & ~pclk_prev_q;
    assign href_fall  = href_prev_q & ~href_s_q[1];
    assign vsync_rise = vsync_s_q[1] & ~vsync_prev_q;
    assign vsync_fall = ~vsync_s_q[1] & vsync_prev_q;

`ifdef CAPTURE_DECIMATE_EN
    // Only parity of the pixel and line counters decides whether a pixel is kept.
    logic pix_odd_q, line_odd_q;
    assign keep = ~pix_odd_q & ~line_odd_q;
`else
    assign keep = 1'b1;
`endif

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            pclk_s_q     <= '0;
            href_s_q     <= '0;
            vsync_s_q    <= '0;
            data_s1_q    <= '0;
            data_s2_q    <= '0;
            pclk_prev_q  <= 1'b0;
            href_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            pclk_s_q     <= {pclk_s_q[0], cam_pclk};
            href_s_q     <= {href_s_q[0], cam_href};
            vsync_s_q    <= {vsync_s_q[0], cam_vsync};
            data_s1_q    <= cam_data;
            data_s2_q    <= data_s1_q;
            pclk_prev_q  <= pclk_s_q[1];
            href_prev_q  <= href_s_q[1];
            vsync_prev_q <= vsync_s_q[1];
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            state_q <= SYNC_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            SYNC_WAIT: begin
                if (vsync_s_q[1]) begin
                    state_d = FRAME_WAIT;
                end
            end
            FRAME_WAIT: begin
                if (vsync_fall) begin
                    state_d     = CAPTURE;
                    frame_start = 1'b1;
                end
            end
            CAPTURE: begin
                if (vsync_rise) begin
                    state_d   = FRAME_WAIT;
                    frame_end = 1'b1;
                end
            end
            default: state_d = SYNC_WAIT;
        endcase
    end

    // Pixel assembly and write generation. The byte handling below is keyed
    // on state_q, so a pixel completing in the same cycle as the vsync edge
    // still produces its write before the state change takes effect.
    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            phase_q      <= 1'b0;
            byte0_q      <= '0;
            addr_q       <= '0;
            full_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
            pix_odd_q    <= 1'b0;
            line_odd_q   <= 1'b0;
`endif
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= frame_end;
            if (frame_start) begin
                phase_q    <= 1'b0;
                addr_q     <= '0;
                wr_addr_q  <= '0;
                full_q     <= 1'b0;
                overflow_q <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
                pix_odd_q  <= 1'b0;
                line_odd_q <= 1'b0;
`endif
            end else if (state_q == CAPTURE) begin
                if (href_fall) begin
                    // A dangling odd byte is dropped here.
                    phase_q    <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
                    pix_odd_q  <= 1'b0;
                    line_odd_q <= ~line_odd_q;
`endif
                end else if (sample && href_s_q[1]) begin
                    phase_q <= ~phase_q;
                    if (!phase_q) begin
                        byte0_q <= data_s2_q;
                    end else begin
`ifdef CAPTURE_DECIMATE_EN
                        pix_odd_q <= ~pix_odd_q;
`endif
                        if (keep) begin
                            if (full_q) begin
                                overflow_q <= 1'b1;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr_q;
                                // {R[4:1], G[5:2], B[4:1]} from {R,G[5:3]} / {G[2:0],B}
                                wr_data_q <= {byte0_q[7:4], byte0_q[2:0], data_s2_q[7], data_s2_q[4:1]};
                                // Address sticks at the last pixel once the frame is full.
                                if (addr_q == LAST_ADDR) begin
                                    full_q <= 1'b1;
                                end else begin
                                    addr_q <= addr_q + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - scoreboard bench for ov7670_capture on a reduced 4x3 frame
module tb_ov7670_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;
`ifdef CAPTURE_DECIMATE_EN
    localparam int DEC = 2;
`else
    localparam int DEC = 1;
`endif
    localparam int IN_H = H * DEC;
    localparam int IN_V = V * DEC;
    localparam int CAP  = H * V;

    logic          clk = 1'b0;
    logic          reset;
    logic          cam_pclk, cam_vsync, cam_href;
    logic [7:0]    cam_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          frame_done, overflow;

    always #5 clk = ~clk;

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .clk100mhz (clk),
        .reset     (reset),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] q_addr[$];
    logic [11:0] q_data[$];
    int          wr_cnt = 0;
    int          fd_cnt = 0;
    logic [31:0] last_addr = 0;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (wr_en) begin
            wr_cnt++;
            last_addr = 32'(wr_addr);
            if (q_addr.size() == 0) begin
                chk("spurious_wr_addr", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(wr_addr), q_addr.pop_front());
                chk("wr_data", 32'(wr_data), 32'(q_data.pop_front()));
            end
        end
    end

    // Reference model of what should be stored.
    int   exp_addr, exp_x, exp_y;
    bit   capturing = 0;
    bit   exp_ovf   = 0;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        cam_data = b;
        cam_href = 1'b1;
        cam_pclk = 1'b0;
        repeat (3) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_pixel(input logic [15:0] p);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
        if (capturing) begin
            if ((exp_x % DEC == 0) && (exp_y % DEC == 0)) begin
                if (exp_addr < CAP) begin
                    q_addr.push_back(32'(exp_addr));
                    q_data.push_back({p[15:12], p[10:7], p[4:1]});
                    exp_addr++;
                end else begin
                    exp_ovf = 1;
                end
            end
            exp_x++;
        end
    endtask

    task automatic end_line();
        @(negedge clk);
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        repeat (8) @(negedge clk);
        exp_x = 0;
        exp_y++;
    endtask

    task automatic frame_start();
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (8) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (8) @(negedge clk);
        exp_addr  = 0;
        exp_x     = 0;
        exp_y     = 0;
        exp_ovf   = 0;
        capturing = 1;
    endtask

    task automatic frame_end();
        @(negedge clk);
        cam_vsync = 1'b1;
        repeat (8) @(negedge clk);
        capturing = 0;
    endtask

    task automatic random_frame(input int lines);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < IN_H; x++) send_pixel(16'($urandom));
            end_line();
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, f0;
        logic [15:0] fixed_px [4];
        fixed_px[0] = 16'hF800;
        fixed_px[1] = 16'h07E0;
        fixed_px[2] = 16'h001F;
        fixed_px[3] = 16'hFFFF;

        reset = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_wr_en",      32'(wr_en),      0);
        chk("rst_wr_addr",    32'(wr_addr),    0);
        chk("rst_wr_data",    32'(wr_data),    0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overflow",   32'(overflow),   0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Known colour bars on one line.
        w0 = wr_cnt; f0 = fd_cnt;
        frame_start();
        for (int i = 0; i < 4; i++) send_pixel(fixed_px[i]);
        end_line();
        frame_end();
        chk("bars_wr_count", 32'(wr_cnt - w0), 32'(4 / DEC));
        chk("bars_frame_done", 32'(fd_cnt - f0), 1);
        chk("bars_sb_empty", 32'(q_addr.size()), 0);

        // Complete frame.
        w0 = wr_cnt; f0 = fd_cnt;
        frame_start();
        random_frame(IN_V);
        frame_end();
        chk("full_wr_count", 32'(wr_cnt - w0), CAP);
        chk("full_last_addr", last_addr, CAP - 1);
        chk("full_frame_done", 32'(fd_cnt - f0), 1);
        chk("full_overflow", 32'(overflow), 0);
        chk("full_sb_empty", 32'(q_addr.size()), 0);

        // One line too many.
        w0 = wr_cnt;
        frame_start();
        random_frame(IN_V + 1);
        frame_end();
        chk("ovf_wr_count", 32'(wr_cnt - w0), CAP);
        chk("ovf_flag", 32'(overflow), 32'(exp_ovf));
        chk("ovf_addr_hold", 32'(wr_addr), CAP - 1);
        frame_start();
        chk("ovf_cleared", 32'(overflow), 0);
        frame_end();

        // Dangling odd byte before href drops.
        frame_start();
        send_pixel(16'h1234);
        send_byte(8'hA5);
        end_line();
        for (int i = 0; i < 2 * DEC; i++) send_pixel(16'($urandom));
        end_line();
        send_pixel(16'hC3A9);
        send_pixel(16'h5A5A);
        end_line();
        frame_end();
        chk("odd_sb_empty", 32'(q_addr.size()), 0);

        // Reset in the middle of a frame, released while vsync is low.
        frame_start();
        for (int x = 0; x < IN_H; x++) send_pixel(16'($urandom));
        end_line();
        send_pixel(16'($urandom));
        repeat (4) @(negedge clk);
        chk("mid_sb_empty", 32'(q_addr.size()), 0);
        reset = 1'b1;
        capturing = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_wr_addr", 32'(wr_addr), 0);
        w0 = wr_cnt;
        send_pixel(16'($urandom));
        end_line();
        for (int x = 0; x < IN_H; x++) send_pixel(16'($urandom));
        end_line();
        chk("mid_no_writes", 32'(wr_cnt - w0), 0);
        w0 = wr_cnt;
        frame_start();
        for (int x = 0; x < IN_H; x++) send_pixel(16'($urandom));
        end_line();
        frame_end();
        chk("mid_resume_count", 32'(wr_cnt - w0), H);
        chk("mid_resume_last", last_addr, H - 1);
        chk("mid_sb_empty_end", 32'(q_addr.size()), 0);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
